// File: rtl/multi_array_initializer_pkg.sv
// rtl/multi_array_initializer_pkg.sv - shared state encodings and default parameters
package multi_array_initializer_pkg;

  typedef enum logic [1:0] {
    ST_UNINIT = 2'b00,
    ST_BUSY   = 2'b01,
    ST_READY  = 2'b10
  } state_t;

  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_ROW_WIDTH  = 32;
  localparam int DEF_NUM_BLOCKS = 4;
  localparam int DEF_NUM_ARRAYS = 2;
  localparam int DEF_AUTO_INIT  = 1;

endpackage

// File: rtl/multi_array_initializer_clock_gater.sv
// rtl/multi_array_initializer_clock_gater.sv - halt gating as a state-update enable
module multi_array_initializer_clock_gater (
  input  logic i_halt,
  output logic o_en
);

  // Enable-style gate: the clock stays free-running and flops simply hold.
  assign o_en = ~i_halt;

endmodule

// File: rtl/multi_array_initializer.sv
// rtl/multi_array_initializer.sv - fills selected arrays with a pattern, row by row
module multi_array_initializer
  import multi_array_initializer_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
  parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
  parameter int NUM_ARRAYS = DEF_NUM_ARRAYS,
  parameter int AUTO_INIT  = DEF_AUTO_INIT
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_halt,
  input  logic                  i_flush_req,
  input  logic [ROW_WIDTH-1:0]  i_flush_data,
  input  logic [NUM_ARRAYS-1:0] i_flush_sel,
  input  logic                  i_wr_ready,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [ROW_WIDTH-1:0]  o_data,
  output logic                  o_wen,
  output logic [NUM_BLOCKS-1:0] o_wmask,
  output logic [NUM_ARRAYS-1:0] o_array_sel,
  output logic                  o_valid,
  output logic                  o_init_complete,
  output logic                  o_ready
);

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ROW_WIDTH-1:0]  r_pattern, w_pattern_nxt;
  logic [NUM_ARRAYS-1:0] r_sel, w_sel_nxt;
  logic                  r_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ROW_WIDTH-1:0]  r_data;
  logic [NUM_BLOCKS-1:0] r_wmask;
  logic [NUM_ARRAYS-1:0] r_array_sel;
  logic                  w_en, w_accept, w_busy_nxt;

  multi_array_initializer_clock_gater u_gater (
    .i_halt (i_halt),
    .o_en   (w_en)
  );

  assign w_accept  = r_valid & i_wr_ready & w_en;
  assign w_cnt_inc = r_cnt + (ADDR_WIDTH+1)'(1);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pattern_nxt = r_pattern;
    w_sel_nxt     = r_sel;
    case (r_state)
      ST_UNINIT: begin
        if (AUTO_INIT != 0) begin
          w_state_nxt   = ST_BUSY;
          w_cnt_nxt     = '0;
          w_pattern_nxt = '0;
          w_sel_nxt     = '1;
        end else begin
          w_state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (i_flush_req && (|i_flush_sel)) begin
          w_state_nxt   = ST_BUSY;
          w_cnt_nxt     = '0;
          w_pattern_nxt = i_flush_data;
          w_sel_nxt     = i_flush_sel;
        end
      end
      ST_BUSY: begin
        // The extra counter bit flags the last row so no wrap write to 0 occurs.
        if (w_accept) begin
          if (w_cnt_inc[ADDR_WIDTH]) begin
            w_state_nxt = ST_READY;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      end
      default: begin
        w_state_nxt = ST_UNINIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt == ST_BUSY);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= ST_UNINIT;
      r_cnt       <= '0;
      r_pattern   <= '0;
      r_sel       <= '0;
      r_valid     <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_wmask     <= '0;
      r_array_sel <= '0;
    end else if (w_en) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_pattern   <= w_pattern_nxt;
      r_sel       <= w_sel_nxt;
      r_valid     <= w_busy_nxt;
      r_addr      <= w_busy_nxt ? w_cnt_nxt[ADDR_WIDTH-1:0] : '0;
      r_data      <= w_busy_nxt ? w_pattern_nxt : '0;
      r_wmask     <= w_busy_nxt ? '1 : '0;
      r_array_sel <= w_busy_nxt ? w_sel_nxt : '0;
    end
  end

  assign o_addr          = r_addr;
  assign o_data          = r_data;
  assign o_wen           = r_valid;
  assign o_wmask         = r_wmask;
  assign o_array_sel     = r_array_sel;
  assign o_valid         = r_valid;
  assign o_init_complete = (r_state == ST_READY);
  assign o_ready         = o_init_complete & ~i_halt;

endmodule
